// File: rtl/wb_writer_pkg.sv
// Shared constants and types for the register-file writer.
package wb_writer_pkg;

    localparam int unsigned WORD_WIDTH     = 32;
    localparam int unsigned REG_ADDR_WIDTH = 5;
    localparam int unsigned WB_FIFO_DEPTH  = 2;

    // Tag for which source owns the write port in a given cycle.
    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_LU  = 1'b1
    } wb_src_e;

endpackage : wb_writer_pkg

// File: rtl/wb_writer_if.sv
// Valid/ready handshake carrying long-latency (load/multiply) results.
// master: the long-latency unit; slave: the writer that accepts results.
interface wb_writer_if #(
    parameter int unsigned WORD_WIDTH     = wb_writer_pkg::WORD_WIDTH,
    parameter int unsigned REG_ADDR_WIDTH = wb_writer_pkg::REG_ADDR_WIDTH
);
    logic                      lu_valid;
    logic                      lu_ready;
    logic [REG_ADDR_WIDTH-1:0] lu_rd;
    logic [WORD_WIDTH-1:0]     lu_data;

    modport master (
        output lu_valid,
        output lu_rd,
        output lu_data,
        input  lu_ready
    );

    modport slave (
        input  lu_valid,
        input  lu_rd,
        input  lu_data,
        output lu_ready
    );
endinterface : wb_writer_if

// File: rtl/wb_writer_fifo.sv
// wb_fifo: synchronous in-order FIFO with simultaneous push/pop at any count.
// DEPTH must be a power of two so the pointers wrap naturally.
module wb_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Next pointer, count and storage contents.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Pointer and count registers; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once counted valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;

endmodule : wb_fifo

// File: rtl/wb_writer.sv
// wb_writer: drives the single register-file write port from the ALU path
// (never stalls) and a buffered long-latency path, and tracks outstanding
// long-latency destinations for RAW stalls.
// Optional macro WB_WAW_CHECK_EN: sticky waw_err when an ALU write targets a
// register that still has a long-latency write outstanding.
module wb_writer
    import wb_writer_pkg::*;
#(
    parameter int unsigned WORD_WIDTH     = wb_writer_pkg::WORD_WIDTH,
    parameter int unsigned REG_ADDR_WIDTH = wb_writer_pkg::REG_ADDR_WIDTH,
    parameter int unsigned FIFO_DEPTH     = wb_writer_pkg::WB_FIFO_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      alu_valid,
    input  logic [REG_ADDR_WIDTH-1:0] alu_rd,
    input  logic [WORD_WIDTH-1:0]     alu_data,
    wb_writer_if.slave                lu,
    input  logic                      iss_valid,
    input  logic [REG_ADDR_WIDTH-1:0] iss_rd,
    input  logic [REG_ADDR_WIDTH-1:0] chk_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] chk_rs2,
    output logic                      busy1,
    output logic                      busy2,
    output logic                      w_en,
    output logic [REG_ADDR_WIDTH-1:0] wa3,
    output logic [WORD_WIDTH-1:0]     wd3,
    output logic                      waw_err
);

    localparam int unsigned NREGS  = 1 << REG_ADDR_WIDTH;
    localparam int unsigned ENT_W  = REG_ADDR_WIDTH + WORD_WIDTH;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

    logic                      w_en_q, w_en_d;
    logic [REG_ADDR_WIDTH-1:0] wa3_q, wa3_d;
    logic [WORD_WIDTH-1:0]     wd3_q, wd3_d;
    logic [NREGS-1:0]          pending_q, pending_d;

    logic                      fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [ENT_W-1:0]          fifo_head;
    logic [CNT_W-1:0]          fifo_count;
    logic [REG_ADDR_WIDTH-1:0] head_rd;
    logic [WORD_WIDTH-1:0]     head_data;

    logic                      lu_fire;
    logic                      load;
    wb_src_e                   sel_src;
    logic [REG_ADDR_WIDTH-1:0] ld_rd;
    logic [WORD_WIDTH-1:0]     ld_data;

    wb_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data ({lu.lu_rd, lu.lu_data}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign {head_rd, head_data} = fifo_head;

    // Ready depends only on registered occupancy, so a full FIFO refuses
    // even in a cycle where the head is being popped.
    assign lu.lu_ready = !rst && (fifo_count < CNT_W'(FIFO_DEPTH));
    assign lu_fire     = lu.lu_valid && lu.lu_ready;

    // Write-port arbitration: ALU, then queued LU, then LU fall-through.
    always_comb begin
        w_en_d    = 1'b0;
        wa3_d     = wa3_q;
        wd3_d     = wd3_q;
        fifo_pop  = 1'b0;
        load      = 1'b0;
        sel_src   = WB_SRC_ALU;
        ld_rd     = '0;
        ld_data   = '0;
        if (alu_valid) begin
            load    = 1'b1;
            sel_src = WB_SRC_ALU;
            ld_rd   = alu_rd;
            ld_data = alu_data;
        end else if (!fifo_empty) begin
            fifo_pop = 1'b1;
            load     = 1'b1;
            sel_src  = WB_SRC_LU;
            ld_rd    = head_rd;
            ld_data  = head_data;
        end else if (lu_fire) begin
            load     = 1'b1;
            sel_src  = WB_SRC_LU;
            ld_rd    = lu.lu_rd;
            ld_data  = lu.lu_data;
        end
        if (load) begin
            w_en_d = (ld_rd != '0);
            wa3_d  = ld_rd;
            wd3_d  = ld_data;
        end
        fifo_push = lu_fire && (alu_valid || !fifo_empty);
    end

    // Scoreboard: clear on LU load, set on issue (set wins), r0 never pending.
    always_comb begin
        pending_d = pending_q;
        if (load && sel_src == WB_SRC_LU) begin
            pending_d[ld_rd] = 1'b0;
        end
        if (iss_valid && iss_rd != '0) begin
            pending_d[iss_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // Output stage and scoreboard registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_en_q    <= 1'b0;
            wa3_q     <= '0;
            wd3_q     <= '0;
            pending_q <= '0;
        end else begin
            w_en_q    <= w_en_d;
            wa3_q     <= wa3_d;
            wd3_q     <= wd3_d;
            pending_q <= pending_d;
        end
    end

    // Push into a full FIFO without a pop would drop a result.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(fifo_push && fifo_full && !fifo_pop))
                else $error("wb_writer: push into full result buffer");
        end
    end

    assign w_en  = w_en_q;
    assign wa3   = wa3_q;
    assign wd3   = wd3_q;
    assign busy1 = pending_q[chk_rs1];
    assign busy2 = pending_q[chk_rs2];

`ifdef WB_WAW_CHECK_EN
    logic waw_err_q, waw_err_d, waw_hit;

    // Sticky flag for ALU writes racing an outstanding long-latency write.
    always_comb begin
        waw_hit   = alu_valid && (alu_rd != '0) && pending_q[alu_rd];
        waw_err_d = waw_err_q | waw_hit;
    end

    // WAW flag register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            waw_err_q <= 1'b0;
        end else begin
            waw_err_q <= waw_err_d;
        end
    end

    // Simulation report of each WAW violation.
    always_ff @(posedge clk) begin
        if (!rst && waw_hit) begin
            $error("wb_writer: WAW on r%0d with long-latency write pending", alu_rd);
        end
    end

    assign waw_err = waw_err_q;
`else
    assign waw_err = 1'b0;
`endif

endmodule : wb_writer

// File: tb/tb_wb_writer.sv
// Directed self-checking bench for wb_writer (32-bit data, 5-bit indices,
// 2-entry buffer).
module tb_wb_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  chk_rs1, chk_rs2;
    logic        busy1, busy2;
    logic        w_en;
    logic [4:0]  wa3;
    logic [31:0] wd3;
    logic        waw_err;

    int checks = 0;
    int errors = 0;

    wb_writer_if #(.WORD_WIDTH(32), .REG_ADDR_WIDTH(5)) lu_if ();

    wb_writer #(
        .WORD_WIDTH     (32),
        .REG_ADDR_WIDTH (5),
        .FIFO_DEPTH     (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .lu        (lu_if.slave),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .chk_rs1   (chk_rs1),
        .chk_rs2   (chk_rs2),
        .busy1     (busy1),
        .busy2     (busy2),
        .w_en      (w_en),
        .wa3       (wa3),
        .wd3       (wd3),
        .waw_err   (waw_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid       = 1'b0;
        alu_rd          = '0;
        alu_data        = '0;
        lu_if.lu_valid  = 1'b0;
        lu_if.lu_rd     = '0;
        lu_if.lu_data   = '0;
        iss_valid       = 1'b0;
        iss_rd          = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        chk_rs1 = '0;
        chk_rs2 = '0;
        step();
        step();
        checks++; if (w_en !== 1'b0) begin errors++; $display("FAIL reset_w_en got %0h exp 0", w_en); end
        checks++; if (wa3 !== 5'd0) begin errors++; $display("FAIL reset_wa3 got %0h exp 0", wa3); end
        checks++; if (wd3 !== 32'd0) begin errors++; $display("FAIL reset_wd3 got %0h exp 0", wd3); end
        checks++; if (lu_if.lu_ready !== 1'b0) begin errors++; $display("FAIL reset_lu_ready got %0h exp 0", lu_if.lu_ready); end
        checks++; if (waw_err !== 1'b0) begin errors++; $display("FAIL reset_waw got %0h exp 0", waw_err); end
        rst = 1'b0;
        #1;
        checks++; if (lu_if.lu_ready !== 1'b1) begin errors++; $display("FAIL idle_lu_ready got %0h exp 1", lu_if.lu_ready); end
        step();
        checks++; if (w_en !== 1'b0) begin errors++; $display("FAIL idle_w_en got %0h exp 0", w_en); end
        for (int i = 0; i < 32; i++) begin
            chk_rs1 = 5'(i);
            chk_rs2 = 5'(31 - i);
            #1;
            checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL idle_busy1 r%0d got %0h exp 0", i, busy1); end
            checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL idle_busy2 r%0d got %0h exp 0", 31 - i, busy2); end
        end
    endtask

    task automatic test_alu();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        step();
        checks++; if (w_en !== 1'b1) begin errors++; $display("FAIL alu_w_en got %0h exp 1", w_en); end
        checks++; if (wa3 !== 5'd5) begin errors++; $display("FAIL alu_wa3 got %0h exp 5", wa3); end
        checks++; if (wd3 !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_wd3 got %0h exp deadbeef", wd3); end
        alu_rd = 5'd0; alu_data = 32'h1;
        step();
        checks++; if (w_en !== 1'b0) begin errors++; $display("FAIL alu_r0_w_en got %0h exp 0", w_en); end
        checks++; if (wa3 !== 5'd0) begin errors++; $display("FAIL alu_r0_wa3 got %0h exp 0", wa3); end
        checks++; if (wd3 !== 32'h1) begin errors++; $display("FAIL alu_r0_wd3 got %0h exp 1", wd3); end
        alu_valid = 1'b0; alu_data = 32'h0;
        step();
        checks++; if (w_en !== 1'b0) begin errors++; $display("FAIL idle_hold_w_en got %0h exp 0", w_en); end
        checks++; if (wd3 !== 32'h1) begin errors++; $display("FAIL idle_hold_wd3 got %0h exp 1", wd3); end
    endtask

    task automatic test_scoreboard();
        iss_valid = 1'b1; iss_rd = 5'd7;
        step();
        iss_valid = 1'b0;
        chk_rs1 = 5'd7; chk_rs2 = 5'd6;
        #1;
        checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL sb_busy_set got %0h exp 1", busy1); end
        checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL sb_busy_other got %0h exp 0", busy2); end
        lu_if.lu_valid = 1'b1; lu_if.lu_rd = 5'd7; lu_if.lu_data = 32'h42;
        #1;
        checks++; if (lu_if.lu_ready !== 1'b1) begin errors++; $display("FAIL sb_lu_ready got %0h exp 1", lu_if.lu_ready); end
        step();
        lu_if.lu_valid = 1'b0;
        checks++; if (w_en !== 1'b1) begin errors++; $display("FAIL lu_direct_w_en got %0h exp 1", w_en); end
        checks++; if (wa3 !== 5'd7) begin errors++; $display("FAIL lu_direct_wa3 got %0h exp 7", wa3); end
        checks++; if (wd3 !== 32'h42) begin errors++; $display("FAIL lu_direct_wd3 got %0h exp 42", wd3); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL sb_busy_clear got %0h exp 0", busy1); end
        step();
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL sb_busy_stays_clear got %0h exp 0", busy1); end
        checks++; if (w_en !== 1'b0) begin errors++; $display("FAIL lu_direct_after got %0h exp 0", w_en); end
        // LU result for r0 completes the handshake but never writes.
        lu_if.lu_valid = 1'b1; lu_if.lu_rd = 5'd0; lu_if.lu_data = 32'h77;
        step();
        lu_if.lu_valid = 1'b0;
        checks++; if (w_en !== 1'b0) begin errors++; $display("FAIL lu_r0_w_en got %0h exp 0", w_en); end
        checks++; if (wd3 !== 32'h77) begin errors++; $display("FAIL lu_r0_wd3 got %0h exp 77", wd3); end
    endtask

    task automatic test_back_to_back();
        // Per step: inputs, expected lu_ready before the edge, expected outputs after.
        logic        t_alu_v [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
        logic        t_lu_v  [8] = '{1, 1, 1, 1, 1, 1, 0, 0};
        logic [4:0]  t_lu_rd [8] = '{3, 4, 5, 5, 5, 5, 0, 0};
        logic        e_ready [8] = '{1, 1, 0, 0, 0, 1, 1, 1};
        logic        e_wen   [8] = '{1, 1, 1, 1, 1, 1, 1, 0};
        logic [4:0]  e_wa3   [8] = '{10, 11, 12, 13, 3, 4, 5, 5};
        logic [31:0] e_wd3   [8] = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'h33, 32'h44, 32'h55, 32'h55};
        for (int k = 0; k < 8; k++) begin
            alu_valid      = t_alu_v[k];
            alu_rd         = 5'(10 + k);
            alu_data       = 32'hA0 + 32'(k);
            lu_if.lu_valid = t_lu_v[k];
            lu_if.lu_rd    = t_lu_rd[k];
            lu_if.lu_data  = {27'd0, t_lu_rd[k]} * 32'h11;
            #1;
            checks++; if (lu_if.lu_ready !== e_ready[k]) begin errors++; $display("FAIL b2b_ready step%0d got %0h exp %0h", k, lu_if.lu_ready, e_ready[k]); end
            step();
            checks++; if (w_en !== e_wen[k]) begin errors++; $display("FAIL b2b_w_en step%0d got %0h exp %0h", k, w_en, e_wen[k]); end
            checks++; if (wa3 !== e_wa3[k]) begin errors++; $display("FAIL b2b_wa3 step%0d got %0h exp %0h", k, wa3, e_wa3[k]); end
            checks++; if (wd3 !== e_wd3[k]) begin errors++; $display("FAIL b2b_wd3 step%0d got %0h exp %0h", k, wd3, e_wd3[k]); end
        end
        idle_inputs();
    endtask

    task automatic test_set_wins();
        iss_valid = 1'b1; iss_rd = 5'd9;
        step();
        lu_if.lu_valid = 1'b1; lu_if.lu_rd = 5'd9; lu_if.lu_data = 32'h99;
        step();
        iss_valid = 1'b0;
        chk_rs1 = 5'd9;
        #1;
        checks++; if (wa3 !== 5'd9 || w_en !== 1'b1) begin errors++; $display("FAIL setwins_write got en=%0h wa3=%0h exp en=1 wa3=9", w_en, wa3); end
        checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL setwins_busy got %0h exp 1", busy1); end
        lu_if.lu_data = 32'h98;
        step();
        lu_if.lu_valid = 1'b0;
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL setwins_later_clear got %0h exp 0", busy1); end
    endtask

    task automatic test_waw();
        iss_valid = 1'b1; iss_rd = 5'd12;
        step();
        iss_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'hC;
        step();
        alu_valid = 1'b0;
        step();
        step();
`ifdef WB_WAW_CHECK_EN
        checks++; if (waw_err !== 1'b1) begin errors++; $display("FAIL waw_sticky got %0h exp 1", waw_err); end
`else
        checks++; if (waw_err !== 1'b0) begin errors++; $display("FAIL waw_tied got %0h exp 0", waw_err); end
`endif
        chk_rs2 = 5'd12;
        #1;
        checks++; if (busy2 !== 1'b1) begin errors++; $display("FAIL waw_pending_kept got %0h exp 1", busy2); end
    endtask

    task automatic test_reset_flush();
        // ALU holds the port so two LU results queue up.
        alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'h20;
        lu_if.lu_valid = 1'b1; lu_if.lu_rd = 5'd21; lu_if.lu_data = 32'h21;
        step();
        lu_if.lu_rd = 5'd22; lu_if.lu_data = 32'h22;
        step();
        lu_if.lu_valid = 1'b0;
        checks++; if (lu_if.lu_ready !== 1'b0) begin errors++; $display("FAIL flush_full got %0h exp 0", lu_if.lu_ready); end
        alu_valid = 1'b0;
        rst = 1'b1;
        step();
        checks++; if (w_en !== 1'b0) begin errors++; $display("FAIL flush_rst_w_en got %0h exp 0", w_en); end
        checks++; if (waw_err !== 1'b0) begin errors++; $display("FAIL flush_waw_clear got %0h exp 0", waw_err); end
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (w_en !== 1'b0) begin errors++; $display("FAIL flush_no_write cyc%0d got %0h exp 0", k, w_en); end
        end
        chk_rs2 = 5'd12;
        #1;
        checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL flush_sb_clear got %0h exp 0", busy2); end
        checks++; if (lu_if.lu_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %0h exp 1", lu_if.lu_ready); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_scoreboard();
        test_back_to_back();
        test_set_wins();
        test_waw();
        test_reset_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_wb_writer
